fusion_operand_sequencer: RTL and testbench
===========================================

# fusion_operand_sequencer

Issue-side driver and collector for one 4×4 fused multiplier built from four 2-bit bitbricks (sft_ctrl 4'b1011 mode).
- Accepts one multiply request per handshake: 4-bit, or 8-bit via temporal fusion.
- Slices the operands into 4-bit passes, drives the multiplier's operand, sign and shift-control pins, and shift-accumulates the returned partial products.
- Returns a 16-bit product over a valid/ready handshake.
- Sits between the PE operand buffers and the fused multiplier.

## Interface
Parameters:
- FU_LAT, 0, cycles from driving fu_* operands to the matching fu_out (0 = combinational)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_a, in_b  in  8 each  operands; only [3:0] used when in_prec=0
- in_sa, in_sb  in  1 each  operand is two's-complement
- in_prec  in  1  0 = 4-bit (1 pass), 1 = 8-bit (4 passes)
- fu_a, fu_b  out  4 each  slice operands to the fused multiplier
- fu_sa, fu_sb  out  2 each  per-bitbrick sign flags
- fu_sft_ctrl_1, fu_sft_ctrl_2  out  1 each  shift control
- fu_sft_ctrl_3  out  2  shift control
- fu_issue  out  1  a pass is driven this cycle
- fu_out  in  16  fused product for the pass issued FU_LAT cycles earlier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts
- out_prod  out  16  product, two's-complement if in_sa||in_sb, else unsigned

## Operation
- FSM: IDLE → RUN → HOLD → IDLE.
- IDLE:
  - in_ready=1.
  - On accept: latch operands, flags and prec; clear acc; set N = prec ? 4 : 1; go RUN.
- RUN:
  - Issue pass p = 0..N-1, one per cycle, fu_issue=1.
  - Capture pass p FU_LAT cycles after issue.
  - After the last capture, go HOLD.
- HOLD:
  - out_valid=1, out_prod=acc.
  - On out_ready, go IDLE.
- Pass table for 8-bit; L = [3:0], H = [7:4]; each pass gives a slice pair and its shift:
  - p0: (aL, bL), shift 0
  - p1: (aH, bL), shift 4
  - p2: (aL, bH), shift 4
  - p3: (aH, bH), shift 8
- 4-bit mode: single pass (a[3:0], b[3:0]), shift 0.
- Slice signedness:
  - A slice is signed iff it is the operand's top slice and the operand is signed.
  - Low slices in 8-bit mode are always unsigned.
  - fu_sa = {slice_a_signed, 1'b0}; fu_sb likewise.
- fu_sft_ctrl_3, fu_sft_ctrl_2, fu_sft_ctrl_1 are fixed at 2'b10, 1, 1 (4'b1011).
- Accumulate:
  - acc += ext16(fu_out[7:0]) << shift, using 16-bit arithmetic, modulo 2^16.
  - ext16 sign-extends iff either slice of the pass is signed; otherwise it zero-extends.
  - fu_out[15:8] is ignored.
  - All 8×8 products (signed, unsigned, mixed) fit 16 bits, so the result is exact.
- Idle/HOLD: fu_a = fu_b = 0, fu_sa = fu_sb = 0, fu_issue = 0.

## Timing
- The accept edge is cycle 0.
- Pass p is driven during cycle p+1.
- Pass p is captured at the end of cycle p+1+FU_LAT.
- out_valid rises in cycle N+FU_LAT+1:
  - 4-bit, FU_LAT=0: 2 cycles.
  - 8-bit, FU_LAT=1: 6 cycles.
- in_ready=0 from accept until the HOLD→IDLE transition. No request overlap; throughput is 1 per N+FU_LAT+2 cycles.
- Earliest next accept is the cycle after out_valid && out_ready.
- out_prod and out_valid are stable while out_ready=0; HOLD lasts indefinitely.
- Reset values:
  - in_ready=0 while rst=1; 1 in the first cycle after.
  - out_valid=0, out_prod=0, fu_issue=0, fu_a/fu_b/fu_sa/fu_sb=0, acc=0, state IDLE, pass and capture counters 0.
- Reset mid-RUN or mid-HOLD aborts the request: no out_valid, and late fu_out is ignored.
- in_valid while busy is ignored; the source holds it.

## Structure
- Package fusion_pkg holds:
  - FUSE_4X4 = 4'b1011
  - prec enum {PREC4, PREC8}
  - state enum {IDLE, RUN, HOLD}
  - SLICE_W = 4, PROD_W = 16
- Sub-module fusion_slice_gen, combinational:
  - Inputs: pass index, latched operands, flags, prec.
  - Outputs: fu_a, fu_b, fu_sa, fu_sb, shift, ext_signed.
  - The capture path reuses it with the FU_LAT-delayed pass index.
- The delayed pass index is a FU_LAT-deep shift register of {valid, p}.

## Test plan
- 4-bit unsigned 15×15, FU_LAT=0 → 0x00E1; out_valid in cycle 2; fu_sa=fu_sb=0.
- 4-bit signed −8×7 → 0xFFC8; fu_sa=fu_sb=2'b10.
- 8-bit unsigned 255×255, FU_LAT=1 → 0xFE01; fu_issue for exactly 4 cycles; out_valid in cycle 6.
- 8-bit signed −128×−128 → 0x4000; mixed signed −1 (0xFF) × unsigned 255 → 0xFF01.
- out_ready low for 5 cycles in HOLD → out_prod stable and in_ready=0; a back-to-back request is accepted the cycle after release.
- Assert rst in cycle 3 of an 8-bit request → no out_valid; all outputs at reset values; the next request 3×5 returns 0x000F.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared types and constants for the fused 4x4 multiplier operand sequencer.
package fusion_pkg;

  localparam logic [3:0]  FUSE_4X4 = 4'b1011;
  localparam int unsigned SLICE_W  = 4;
  localparam int unsigned PROD_W   = 16;

  typedef enum logic {
    PREC4 = 1'b0,
    PREC8 = 1'b1
  } prec_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

endpackage

// File: rtl/fusion_slice_gen.sv
// Maps a pass index onto operand slices, bitbrick sign flags and accumulate shift.
module fusion_slice_gen
  import fusion_pkg::*;
(
  input  logic [1:0]         i_pass,
  input  logic [7:0]         i_a,
  input  logic [7:0]         i_b,
  input  logic               i_sa,
  input  logic               i_sb,
  input  prec_e              i_prec,
  output logic [SLICE_W-1:0] o_fu_a,
  output logic [SLICE_W-1:0] o_fu_b,
  output logic [1:0]         o_fu_sa,
  output logic [1:0]         o_fu_sb,
  output logic [3:0]         o_shift,
  output logic               o_ext_signed
);

  logic w_a_hi;
  logic w_b_hi;
  logic w_a_signed;
  logic w_b_signed;

  // Pass bit 0 selects the high A slice, bit 1 the high B slice.
  assign w_a_hi     = (i_prec == PREC8) && i_pass[0];
  assign w_b_hi     = (i_prec == PREC8) && i_pass[1];
  assign w_a_signed = i_sa && ((i_prec == PREC4) || w_a_hi);
  assign w_b_signed = i_sb && ((i_prec == PREC4) || w_b_hi);

  assign o_fu_a       = w_a_hi ? i_a[7:4] : i_a[3:0];
  assign o_fu_b       = w_b_hi ? i_b[7:4] : i_b[3:0];
  assign o_fu_sa      = {w_a_signed, 1'b0};
  assign o_fu_sb      = {w_b_signed, 1'b0};
  assign o_shift      = {w_a_hi && w_b_hi, w_a_hi ^ w_b_hi, 2'b00};
  assign o_ext_signed = w_a_signed || w_b_signed;

endmodule

// File: rtl/fusion_operand_sequencer.sv
// Issues 4-bit operand passes to a fused 4x4 multiplier and shift-accumulates
// the returned partial products into a 16-bit result.
module fusion_operand_sequencer
  import fusion_pkg::*;
#(
  parameter int unsigned FU_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_a,
  input  logic [7:0]          in_b,
  input  logic                in_sa,
  input  logic                in_sb,
  input  logic                in_prec,
  output logic [SLICE_W-1:0]  fu_a,
  output logic [SLICE_W-1:0]  fu_b,
  output logic [1:0]          fu_sa,
  output logic [1:0]          fu_sb,
  output logic                fu_sft_ctrl_1,
  output logic                fu_sft_ctrl_2,
  output logic [1:0]          fu_sft_ctrl_3,
  output logic                fu_issue,
  input  logic [PROD_W-1:0]   fu_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   out_prod
);

  state_e              r_state;
  state_e              w_next;
  logic [7:0]          r_a;
  logic [7:0]          r_b;
  logic                r_sa;
  logic                r_sb;
  prec_e               r_prec;
  logic [PROD_W-1:0]   r_acc;
  logic [2:0]          r_issue_cnt;
  logic [2:0]          r_cap_cnt;
  logic [2:0]          w_npass;
  logic                w_accept;
  logic                w_issuing;
  logic                w_cap_valid;
  logic [1:0]          w_cap_pass;
  logic                w_last_cap;

  logic [SLICE_W-1:0]  w_iss_a;
  logic [SLICE_W-1:0]  w_iss_b;
  logic [1:0]          w_iss_sa;
  logic [1:0]          w_iss_sb;
  logic [3:0]          w_unused_iss_shift;
  logic                w_unused_iss_ext;

  logic [3:0]          w_cap_shift;
  logic                w_cap_ext;
  logic [SLICE_W-1:0]  w_unused_cap_a;
  logic [SLICE_W-1:0]  w_unused_cap_b;
  logic [1:0]          w_unused_cap_sa;
  logic [1:0]          w_unused_cap_sb;
  logic [7:0]          w_unused_fu_hi;
  logic [PROD_W-1:0]   w_part;

  assign w_npass     = (r_prec == PREC8) ? 3'd4 : 3'd1;
  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_issuing   = (r_state == RUN) && (r_issue_cnt < w_npass);
  assign w_last_cap  = w_cap_valid && (r_cap_cnt == (w_npass - 3'd1));

  fusion_slice_gen u_issue_slice (
    .i_pass       (r_issue_cnt[1:0]),
    .i_a          (r_a),
    .i_b          (r_b),
    .i_sa         (r_sa),
    .i_sb         (r_sb),
    .i_prec       (r_prec),
    .o_fu_a       (w_iss_a),
    .o_fu_b       (w_iss_b),
    .o_fu_sa      (w_iss_sa),
    .o_fu_sb      (w_iss_sb),
    .o_shift      (w_unused_iss_shift),
    .o_ext_signed (w_unused_iss_ext)
  );

  // The capture side re-derives shift/extension from the delayed pass index.
  fusion_slice_gen u_capture_slice (
    .i_pass       (w_cap_pass),
    .i_a          (r_a),
    .i_b          (r_b),
    .i_sa         (r_sa),
    .i_sb         (r_sb),
    .i_prec       (r_prec),
    .o_fu_a       (w_unused_cap_a),
    .o_fu_b       (w_unused_cap_b),
    .o_fu_sa      (w_unused_cap_sa),
    .o_fu_sb      (w_unused_cap_sb),
    .o_shift      (w_cap_shift),
    .o_ext_signed (w_cap_ext)
  );

  if (FU_LAT == 0) begin : g_no_delay
    assign w_cap_valid = w_issuing;
    assign w_cap_pass  = r_issue_cnt[1:0];
  end else begin : g_delay
    logic       r_dly_v [FU_LAT];
    logic [1:0] r_dly_p [FU_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < FU_LAT; i++) begin
          r_dly_v[i] <= 1'b0;
          r_dly_p[i] <= '0;
        end
      end else begin
        r_dly_v[0] <= w_issuing;
        r_dly_p[0] <= r_issue_cnt[1:0];
        for (int unsigned i = 1; i < FU_LAT; i++) begin
          r_dly_v[i] <= r_dly_v[i-1];
          r_dly_p[i] <= r_dly_p[i-1];
        end
      end
    end

    assign w_cap_valid = r_dly_v[FU_LAT-1] && (r_state == RUN);
    assign w_cap_pass  = r_dly_p[FU_LAT-1];
  end

  assign w_unused_fu_hi = fu_out[15:8];
  assign w_part = (w_cap_ext ? {{8{fu_out[7]}}, fu_out[7:0]}
                             : {8'h00, fu_out[7:0]}) << w_cap_shift;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_next = RUN;
      RUN:     if (w_last_cap) w_next = HOLD;
      HOLD:    if (out_ready)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_prec      <= PREC4;
      r_acc       <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a         <= in_a;
        r_b         <= in_b;
        r_sa        <= in_sa;
        r_sb        <= in_sb;
        r_prec      <= prec_e'(in_prec);
        r_acc       <= '0;
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
      end else begin
        if (w_issuing) begin
          r_issue_cnt <= r_issue_cnt + 3'd1;
        end
        if (w_cap_valid) begin
          r_cap_cnt <= r_cap_cnt + 3'd1;
          r_acc     <= r_acc + w_part;
        end
      end
    end
  end

  assign fu_a          = w_issuing ? w_iss_a  : '0;
  assign fu_b          = w_issuing ? w_iss_b  : '0;
  assign fu_sa         = w_issuing ? w_iss_sa : '0;
  assign fu_sb         = w_issuing ? w_iss_sb : '0;
  assign fu_issue      = w_issuing;
  assign fu_sft_ctrl_3 = FUSE_4X4[3:2];
  assign fu_sft_ctrl_2 = FUSE_4X4[1];
  assign fu_sft_ctrl_1 = FUSE_4X4[0];
  assign out_valid     = (r_state == HOLD);
  assign out_prod      = r_acc;

endmodule

// File: tb/tb_fusion_operand_sequencer.sv
// Directed bench: two sequencers (FU_LAT=0 and FU_LAT=1) each driving a modelled
// fused multiplier, checked every cycle against an arithmetic reference model.
module tb_fusion_operand_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_b      [2];
  logic        in_sa     [2];
  logic        in_sb     [2];
  logic        in_prec   [2];
  logic [3:0]  fu_a      [2];
  logic [3:0]  fu_b      [2];
  logic [1:0]  fu_sa     [2];
  logic [1:0]  fu_sb     [2];
  logic        fu_c1     [2];
  logic        fu_c2     [2];
  logic [1:0]  fu_c3     [2];
  logic        fu_issue  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_prod  [2];
  logic [15:0] fu_out0;
  logic [15:0] fu_out1;

  int n_chk  = 0;
  int n_pass = 0;

  // Fused multiplier: product of two 4-bit slices, each signed per its flag.
  function automatic logic [15:0] mul4(input logic [3:0] a, input logic [3:0] b,
                                       input logic sa, input logic sb);
    int va;
    int vb;
    va = sa ? int'($signed(a)) : int'(a);
    vb = sb ? int'($signed(b)) : int'(b);
    return 16'(va * vb);
  endfunction

  assign fu_out0 = mul4(fu_a[0], fu_b[0], fu_sa[0][1], fu_sb[0][1]);
  always @(posedge clk) fu_out1 <= mul4(fu_a[1], fu_b[1], fu_sa[1][1], fu_sb[1][1]);

  fusion_operand_sequencer #(.FU_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_sa(in_sa[0]), .in_sb(in_sb[0]), .in_prec(in_prec[0]),
    .fu_a(fu_a[0]), .fu_b(fu_b[0]), .fu_sa(fu_sa[0]), .fu_sb(fu_sb[0]),
    .fu_sft_ctrl_1(fu_c1[0]), .fu_sft_ctrl_2(fu_c2[0]), .fu_sft_ctrl_3(fu_c3[0]),
    .fu_issue(fu_issue[0]), .fu_out(fu_out0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_prod(out_prod[0])
  );

  fusion_operand_sequencer #(.FU_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_sa(in_sa[1]), .in_sb(in_sb[1]), .in_prec(in_prec[1]),
    .fu_a(fu_a[1]), .fu_b(fu_b[1]), .fu_sa(fu_sa[1]), .fu_sb(fu_sb[1]),
    .fu_sft_ctrl_1(fu_c1[1]), .fu_sft_ctrl_2(fu_c2[1]), .fu_sft_ctrl_3(fu_c3[1]),
    .fu_issue(fu_issue[1]), .fu_out(fu_out1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_prod(out_prod[1])
  );

  // Reference model state per instance (instance index equals its FU_LAT).
  logic        m_busy  [2];
  logic        m_fresh [2];
  int          m_k     [2];
  int          m_first [2];
  logic [7:0]  m_a     [2];
  logic [7:0]  m_b     [2];
  logic        m_sa    [2];
  logic        m_sb    [2];
  logic        m_prec  [2];
  logic [15:0] m_exp   [2];
  logic [15:0] lit_exp [2];
  int          lit_lat [2];

  task automatic chk(input string name, input int inst, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
  endtask

  task automatic model_step(input int i);
    int          n;
    int          k;
    int          va;
    int          vb;
    logic        iss;
    logic        ev;
    logic [3:0]  ea;
    logic [3:0]  eb;
    logic        esa;
    logic        esb;
    logic [7:0]  ta;
    logic [7:0]  tb;
    if (rst) begin
      chk("in_ready_rst", i, 16'(in_ready[i]), 16'd0);
      m_busy[i]  = 1'b0;
      m_fresh[i] = 1'b1;
      return;
    end
    chk("sft_ctrl", i, 16'({fu_c3[i], fu_c2[i], fu_c1[i]}), 16'b1011);
    if (!m_busy[i]) begin
      chk("in_ready_idle", i, 16'(in_ready[i]), 16'd1);
      chk("fu_issue_idle", i, 16'(fu_issue[i]), 16'd0);
      chk("fu_ab_idle", i, 16'({fu_a[i], fu_b[i], fu_sa[i], fu_sb[i]}), 16'd0);
      chk("out_valid_idle", i, 16'(out_valid[i]), 16'd0);
      if (m_fresh[i]) chk("out_prod_reset", i, out_prod[i], 16'd0);
      if (in_valid[i]) begin
        m_a[i] = in_a[i]; m_b[i] = in_b[i];
        m_sa[i] = in_sa[i]; m_sb[i] = in_sb[i]; m_prec[i] = in_prec[i];
        ta = in_a[i]; tb = in_b[i];
        if (in_prec[i]) begin
          va = in_sa[i] ? int'($signed(ta)) : int'(ta);
          vb = in_sb[i] ? int'($signed(tb)) : int'(tb);
        end else begin
          va = in_sa[i] ? int'($signed(ta[3:0])) : int'(ta[3:0]);
          vb = in_sb[i] ? int'($signed(tb[3:0])) : int'(tb[3:0]);
        end
        m_exp[i]   = 16'(va * vb);
        m_busy[i]  = 1'b1;
        m_fresh[i] = 1'b0;
        m_k[i]     = 1;
        m_first[i] = -1;
      end
    end else begin
      n  = m_prec[i] ? 4 : 1;
      k  = m_k[i];
      ta = m_a[i];
      tb = m_b[i];
      chk("in_ready_busy", i, 16'(in_ready[i]), 16'd0);
      iss = (k >= 1) && (k <= n);
      ea = '0; eb = '0; esa = 1'b0; esb = 1'b0;
      if (iss) begin
        if (!m_prec[i]) begin
          ea = ta[3:0]; eb = tb[3:0]; esa = m_sa[i]; esb = m_sb[i];
        end else begin
          case (k - 1)
            0:       begin ea = ta[3:0]; eb = tb[3:0]; end
            1:       begin ea = ta[7:4]; eb = tb[3:0]; esa = m_sa[i]; end
            2:       begin ea = ta[3:0]; eb = tb[7:4]; esb = m_sb[i]; end
            default: begin ea = ta[7:4]; eb = tb[7:4]; esa = m_sa[i]; esb = m_sb[i]; end
          endcase
        end
      end
      chk("fu_issue", i, 16'(fu_issue[i]), 16'(iss));
      chk("fu_a", i, 16'(fu_a[i]), 16'(ea));
      chk("fu_b", i, 16'(fu_b[i]), 16'(eb));
      chk("fu_sa", i, 16'(fu_sa[i]), 16'({esa, 1'b0}));
      chk("fu_sb", i, 16'(fu_sb[i]), 16'({esb, 1'b0}));
      ev = (k >= n + i + 1);
      chk("out_valid", i, 16'(out_valid[i]), 16'(ev));
      if (out_valid[i] && m_first[i] < 0) m_first[i] = k;
      if (ev) chk("out_prod", i, out_prod[i], m_exp[i]);
      if (ev && out_ready[i]) begin
        chk("latency_lit", i, 16'(m_first[i]), 16'(lit_lat[i]));
        chk("out_prod_lit", i, out_prod[i], lit_exp[i]);
        m_busy[i] = 1'b0;
      end
      m_k[i] = k + 1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic sa, input logic sb, input logic prec,
                      input logic [15:0] exp, input int lat);
    logic seen;
    lit_exp[idx] = exp;
    lit_lat[idx] = lat;
    in_a[idx] = a; in_b[idx] = b; in_sa[idx] = sa; in_sb[idx] = sb; in_prec[idx] = prec;
    in_valid[idx] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = in_ready[idx];
    end
    if (!seen) begin
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1", idx);
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic collect(input int idx, input int hold);
    logic seen;
    out_ready[idx] = (hold == 0);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid[idx];
    end
    if (!seen) begin
      $display("FAIL valid_timeout dut%0d: out_valid stayed 0, expected 1", idx);
      $fatal(1, "valid timeout");
    end
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      out_ready[idx] = 1'b1;
    end
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
  endtask

  task automatic xact(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic sa, input logic sb, input logic prec,
                      input logic [15:0] exp, input int lat, input int hold);
    send(idx, a, b, sa, sb, prec, exp, lat);
    collect(idx, hold);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      in_sa[i] = 1'b0; in_sb[i] = 1'b0; in_prec[i] = 1'b0;
      out_ready[i] = 1'b0; m_busy[i] = 1'b0; m_fresh[i] = 1'b1;
      lit_exp[i] = '0; lit_lat[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    xact(0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 16'h00E1, 2, 0);
    xact(0, 8'h08, 8'h07, 1'b1, 1'b1, 1'b0, 16'hFFC8, 2, 0);
    xact(0, 8'h9C, 8'h37, 1'b1, 1'b0, 1'b1, 16'hEA84, 5, 0);
    xact(1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 16'hFE01, 6, 0);
    xact(1, 8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 16'h4000, 6, 0);
    xact(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 16'hFF01, 6, 5);
    xact(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 16'h03A8, 6, 0);

    // Abort an 8-bit request with reset driven during cycle 3.
    send(1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h0001, 6);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    xact(1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 16'h000F, 3, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
